gcn_schedule_ctrl: RTL and testbench
====================================

GCN_SCHEDULE_CTRL -- requirements
Module: gcn_schedule_ctrl

Interface
REQ-001 SHALL have parameter FEATURE_ROWS, default 6, number of node feature rows.
REQ-002 SHALL have parameter WEIGHT_COLS, default 3, number of weight columns.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 13, memory read address width.
REQ-004 SHALL have parameter FEATURE_BASE, default 512, first feature-row address.
REQ-005 SHALL have parameter COO_NUM_OF_COLS, default 6, number of COO edge columns.
REQ-006 SHALL have one clock and a synchronous active-high reset.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port start, input, 1, level request to run one full pass.
REQ-010 SHALL have port mac_done, input, 1, datapath dot-product complete pulse.
REQ-011 SHALL have port enable_read, output, 1, memory read strobe.
REQ-012 SHALL have port read_address, output, ADDRESS_WIDTH, memory row address.
REQ-013 SHALL have ports load_weight and load_feature, output, 1 each, latch returned data_in into weight/feature register.
REQ-014 SHALL have port mac_start, output, 1, single-cycle dot-product launch.
REQ-015 SHALL have ports wr_en (1), wr_row ($clog2(FEATURE_ROWS)), wr_col ($clog2(WEIGHT_COLS)), output, result-buffer write.
REQ-016 SHALL have ports coo_address ($clog2(COO_NUM_OF_COLS)) and coo_valid (1), output, aggregation edge index.
REQ-017 SHALL have ports busy and done, output, 1 each, status.

Function
REQ-018 SHALL implement states IDLE, RD_W, LD_W, RD_F, LD_F, MAC, WAIT, WR, AGG, DONE; registered (Moore) outputs.
REQ-019 IDLE: start=1 -> RD_W next cycle, w=0, f=0; otherwise stay.
REQ-020 RD_W: enable_read=1, read_address=w -> LD_W; LD_W: load_weight=1 -> RD_F.
REQ-021 RD_F: enable_read=1, read_address=FEATURE_BASE+f -> LD_F; LD_F: load_feature=1 -> MAC.
REQ-022 MAC: mac_start=1 exactly one cycle -> WAIT; WAIT held until mac_done=1 sampled, then -> WR.
REQ-023 mac_done SHALL be ignored in every state other than WAIT.
REQ-024 WR: wr_en=1, wr_row=f, wr_col=w; f<FEATURE_ROWS-1 -> f+1, RD_F; else f=0 and, if w<WEIGHT_COLS-1, w+1, RD_W; else AGG.
REQ-025 AGG: coo_valid=1, coo_address counts 0..COO_NUM_OF_COLS-1, one per cycle; after last -> DONE.
REQ-026 DONE: done=1; stays until start=0 sampled, then -> IDLE.
REQ-027 busy=1 in every state except IDLE and DONE; start changes while busy SHALL be ignored.
REQ-028 Outputs not active in the current state SHALL be 0 (read_address, wr_row, wr_col, coo_address included).
REQ-029 Counters SHALL never exceed their terminal value; no wrap except by explicit reset to 0 per REQ-024/025.
REQ-030 Per row cost 4+k cycles, where mac_done arrives k>=1 cycles after mac_start; per weight column 2+FEATURE_ROWS*(4+k).

Reset
REQ-031 reset=1 at any rising edge, including mid-pass, SHALL force IDLE, zero all counters, all outputs 0 next cycle.
REQ-032 reset SHALL take priority over start and mac_done in the same cycle.

Verification
REQ-033 Defaults, mac_done 3 cycles after each mac_start, start=1 at cycle 0 -> first RD_W at 1, 18 wr_en pulses, first coo_valid at 133, done=1 at 139.
REQ-034 Address order check -> read_address sequence 0,512..517,1,512..517,2,512..517, each with enable_read=1 for one cycle.
REQ-035 Write order check -> (wr_row,wr_col) = (0,0)..(5,0),(0,1)..(5,2); coo_address 0..5 contiguous.
REQ-036 mac_done pulsed in MAC and RD_F cycles, withheld 20 cycles in WAIT -> FSM stays in WAIT, no wr_en until genuine mac_done.
REQ-037 reset asserted during WAIT of row 3, col 1 -> all outputs 0 next cycle; fresh start reruns from read_address 0.
REQ-038 start held high after done -> done stays 1, no new pass; start=0 -> IDLE; start=1 -> new pass, busy=1.

Source files
------------

// File: rtl/gcn_schedule_ctrl_if.sv
// Handshake bundle between the GCN schedule controller and its datapath.
// Carries start/done status, memory read strobes, MAC control and result writes.
interface gcn_schedule_ctrl_if #(
    parameter int FEATURE_ROWS    = 6,
    parameter int WEIGHT_COLS     = 3,
    parameter int ADDRESS_WIDTH   = 13,
    parameter int COO_NUM_OF_COLS = 6
);
    localparam int RW = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
    localparam int CW = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
    localparam int KW = (COO_NUM_OF_COLS > 1) ? $clog2(COO_NUM_OF_COLS) : 1;

    logic                     start;
    logic                     mac_done;
    logic                     enable_read;
    logic [ADDRESS_WIDTH-1:0] read_address;
    logic                     load_weight;
    logic                     load_feature;
    logic                     mac_start;
    logic                     wr_en;
    logic [RW-1:0]            wr_row;
    logic [CW-1:0]            wr_col;
    logic [KW-1:0]            coo_address;
    logic                     coo_valid;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, mac_done,
        output enable_read, read_address, load_weight, load_feature,
        output mac_start, wr_en, wr_row, wr_col,
        output coo_address, coo_valid, busy, done
    );

    modport slave (
        output start, mac_done,
        input  enable_read, read_address, load_weight, load_feature,
        input  mac_start, wr_en, wr_row, wr_col,
        input  coo_address, coo_valid, busy, done
    );
endinterface

// File: rtl/gcn_schedule_ctrl.sv
// GCN layer scheduler: walks weight columns x feature rows through the MAC,
// then sweeps the COO edge list. All outputs are registered from next state.
module gcn_schedule_ctrl #(
    parameter int FEATURE_ROWS    = 6,
    parameter int WEIGHT_COLS     = 3,
    parameter int ADDRESS_WIDTH   = 13,
    parameter int FEATURE_BASE    = 512,
    parameter int COO_NUM_OF_COLS = 6
) (
    input  logic                clk,
    input  logic                reset,
    gcn_schedule_ctrl_if.master bus
);
    localparam int RW = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
    localparam int CW = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
    localparam int KW = (COO_NUM_OF_COLS > 1) ? $clog2(COO_NUM_OF_COLS) : 1;

    localparam logic [RW-1:0] F_LAST = RW'(FEATURE_ROWS - 1);
    localparam logic [CW-1:0] W_LAST = CW'(WEIGHT_COLS - 1);
    localparam logic [KW-1:0] C_LAST = KW'(COO_NUM_OF_COLS - 1);

    typedef enum logic [3:0] {
        IDLE, RD_W, LD_W, RD_F, LD_F, MAC, WAIT, WR, AGG, DONE
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] w, w_d;
    logic [RW-1:0] f, f_d;
    logic [KW-1:0] c, c_d;

    logic                     en_rd_d, en_rd_q;
    logic [ADDRESS_WIDTH-1:0] addr_d, addr_q;
    logic                     ld_w_d, ld_w_q;
    logic                     ld_f_d, ld_f_q;
    logic                     mac_d, mac_q;
    logic                     wr_d, wr_q;
    logic [RW-1:0]            row_d, row_q;
    logic [CW-1:0]            col_d, col_q;
    logic [KW-1:0]            coo_d, coo_q;
    logic                     cv_d, cv_q;
    logic                     busy_d, busy_q;
    logic                     done_d, done_q;

    always_comb begin
        state_d = state;
        w_d     = w;
        f_d     = f;
        c_d     = c;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d = RD_W;
                    w_d     = '0;
                    f_d     = '0;
                end
            end
            RD_W: state_d = LD_W;
            LD_W: state_d = RD_F;
            RD_F: state_d = LD_F;
            LD_F: state_d = MAC;
            MAC:  state_d = WAIT;
            WAIT: if (bus.mac_done) state_d = WR;
            WR: begin
                if (f != F_LAST) begin
                    f_d     = f + 1'b1;
                    state_d = RD_F;
                end else begin
                    f_d = '0;
                    if (w != W_LAST) begin
                        w_d     = w + 1'b1;
                        state_d = RD_W;
                    end else begin
                        c_d     = '0;
                        state_d = AGG;
                    end
                end
            end
            AGG: begin
                if (c == C_LAST) state_d = DONE;
                else             c_d = c + 1'b1;
            end
            DONE: if (!bus.start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode from the upcoming state so outputs land in the same cycle as it.
    always_comb begin
        en_rd_d = 1'b0;
        addr_d  = '0;
        ld_w_d  = 1'b0;
        ld_f_d  = 1'b0;
        mac_d   = 1'b0;
        wr_d    = 1'b0;
        row_d   = '0;
        col_d   = '0;
        coo_d   = '0;
        cv_d    = 1'b0;
        busy_d  = (state_d != IDLE) && (state_d != DONE);
        done_d  = 1'b0;
        unique case (state_d)
            RD_W: begin
                en_rd_d = 1'b1;
                addr_d  = ADDRESS_WIDTH'(w_d);
            end
            LD_W: ld_w_d = 1'b1;
            RD_F: begin
                en_rd_d = 1'b1;
                addr_d  = ADDRESS_WIDTH'(FEATURE_BASE)
                        + ADDRESS_WIDTH'(f_d);
            end
            LD_F: ld_f_d = 1'b1;
            MAC:  mac_d  = 1'b1;
            WR: begin
                wr_d  = 1'b1;
                row_d = f_d;
                col_d = w_d;
            end
            AGG: begin
                cv_d  = 1'b1;
                coo_d = c_d;
            end
            DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            w       <= '0;
            f       <= '0;
            c       <= '0;
            en_rd_q <= 1'b0;
            addr_q  <= '0;
            ld_w_q  <= 1'b0;
            ld_f_q  <= 1'b0;
            mac_q   <= 1'b0;
            wr_q    <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            coo_q   <= '0;
            cv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            w       <= w_d;
            f       <= f_d;
            c       <= c_d;
            en_rd_q <= en_rd_d;
            addr_q  <= addr_d;
            ld_w_q  <= ld_w_d;
            ld_f_q  <= ld_f_d;
            mac_q   <= mac_d;
            wr_q    <= wr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            coo_q   <= coo_d;
            cv_q    <= cv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.enable_read  = en_rd_q;
    assign bus.read_address = addr_q;
    assign bus.load_weight  = ld_w_q;
    assign bus.load_feature = ld_f_q;
    assign bus.mac_start    = mac_q;
    assign bus.wr_en        = wr_q;
    assign bus.wr_row       = row_q;
    assign bus.wr_col       = col_q;
    assign bus.coo_address  = coo_q;
    assign bus.coo_valid    = cv_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_gcn_schedule_ctrl.sv
// Directed bench for gcn_schedule_ctrl: full pass timing and ordering,
// spurious/late mac_done, mid-pass reset and done/start release.
module tb_gcn_schedule_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gcn_schedule_ctrl_if bus ();
    gcn_schedule_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int   tests = 0;
    int   fails = 0;
    logic auto_en = 1'b0;
    logic auto_done = 1'b0;
    logic man_done = 1'b0;
    int   mcnt = 0;

    assign bus.mac_done = auto_en ? auto_done : man_done;

    // Datapath stand-in: mac_done three cycles after each mac_start.
    initial forever begin
        @(posedge clk);
        #2;
        auto_done = 1'b0;
        if (!auto_en) mcnt = 0;
        else begin
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) auto_done = 1'b1;
            end
            if (bus.mac_start) mcnt = 3;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [28:0] outs();
        return {bus.enable_read, bus.read_address, bus.load_weight,
                bus.load_feature, bus.mac_start, bus.wr_en, bus.wr_row,
                bus.wr_col, bus.coo_address, bus.coo_valid, bus.busy,
                bus.done};
    endfunction

    logic [12:0] exp_addr[$], got_addr[$];
    logic [4:0]  exp_wr[$], got_wr[$];
    logic [2:0]  got_coo[$];
    int cyc, first_rd, first_coo, done_cyc, n_mac, n_wr, bad;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        tick();
        tick();
        chk("reset_outputs", 32'(outs()), 0);
        reset = 1'b0;
        tick();
        chk("idle_outputs", 32'(outs()), 0);

        for (int wi = 0; wi < 3; wi++) begin
            exp_addr.push_back(13'(wi));
            for (int fi = 0; fi < 6; fi++) begin
                exp_addr.push_back(13'(512 + fi));
                exp_wr.push_back({3'(fi), 2'(wi)});
            end
        end

        // Full pass, start at cycle 0.
        auto_en   = 1'b1;
        bus.start = 1'b1;
        cyc = 0; first_rd = -1; first_coo = -1; done_cyc = -1;
        n_mac = 0; bad = 0;
        for (int k = 0; k < 400 && done_cyc < 0; k++) begin
            tick();
            cyc++;
            if (cyc == 2) bus.start = 1'b0;
            if (cyc == 1) chk("busy_cycle1", 32'(bus.busy), 1);
            if (bus.enable_read) begin
                if (first_rd < 0) first_rd = cyc;
                got_addr.push_back(bus.read_address);
            end else if (bus.read_address != 0) bad++;
            if (bus.wr_en) got_wr.push_back({bus.wr_row, bus.wr_col});
            else if ({bus.wr_row, bus.wr_col} != 0) bad++;
            if (bus.coo_valid) begin
                if (first_coo < 0) first_coo = cyc;
                got_coo.push_back(bus.coo_address);
            end else if (bus.coo_address != 0) bad++;
            if (bus.mac_start) n_mac++;
            if (bus.done) done_cyc = cyc;
        end
        chk("busy_at_done", 32'(bus.busy), 0);
        chk("first_rd_cycle", first_rd, 1);
        chk("first_coo_cycle", first_coo, 133);
        chk("done_cycle", done_cyc, 139);
        chk("mac_start_count", n_mac, 18);
        chk("inactive_zero", bad, 0);
        chk("rd_count", got_addr.size(), 21);
        for (int i = 0; i < 21; i++)
            chk($sformatf("rd_addr[%0d]", i),
                (i < got_addr.size()) ? 32'(got_addr[i]) : 32'hFFFF,
                32'(exp_addr[i]));
        chk("wr_count", got_wr.size(), 18);
        for (int i = 0; i < 18; i++)
            chk($sformatf("wr_pos[%0d]", i),
                (i < got_wr.size()) ? 32'(got_wr[i]) : 32'hFFFF,
                32'(exp_wr[i]));
        chk("coo_count", got_coo.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("coo_addr[%0d]", i),
                (i < got_coo.size()) ? 32'(got_coo[i]) : 32'hFFFF, i);
        tick();
        chk("idle_after_done", {30'd0, bus.done, bus.busy}, 0);

        // Spurious mac_done in RD_F and MAC, then a long WAIT.
        auto_en   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("rdf_addr", 32'(bus.read_address), 512);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick();
        chk("mac_pulse", 32'(bus.mac_start), 1);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("wait_no_wr", {30'd0, bus.wr_en, bus.mac_start}, 0);
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.wr_en || !bus.busy || bus.mac_start) bad++;
        end
        chk("wait_hold", bad, 0);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("wr_after_done", 32'(bus.wr_en), 1);
        chk("wr_first_pos", 32'({bus.wr_row, bus.wr_col}), 0);

        // Run to WAIT of row 3, column 1, then reset.
        auto_en = 1'b1;
        n_wr = 1;
        for (int k = 0; k < 400 && n_wr < 9; k++) begin
            tick();
            if (bus.wr_en) n_wr++;
        end
        for (int k = 0; k < 40 && !bus.mac_start; k++) tick();
        chk("mac_r3c1", 32'(bus.mac_start), 1);
        tick();
        chk("wait_r3c1", {30'd0, bus.busy, bus.wr_en}, 2);
        reset = 1'b1;
        tick();
        auto_en = 1'b0;
        chk("reset_mid_pass", 32'(outs()), 0);
        bus.start = 1'b1;
        tick();
        chk("reset_priority", 32'(outs()), 0);
        reset = 1'b0;
        tick();
        chk("restart_read", 32'(bus.enable_read), 1);
        chk("restart_addr", 32'(bus.read_address), 0);

        // Start held high through done.
        auto_en = 1'b1;
        for (int k = 0; k < 400 && !bus.done; k++) tick();
        chk("pass_done", 32'(bus.done), 1);
        bad = 0;
        repeat (5) begin
            tick();
            if (!bus.done || bus.busy || bus.enable_read) bad++;
        end
        chk("done_hold", bad, 0);
        bus.start = 1'b0;
        tick();
        chk("idle_on_release", {30'd0, bus.done, bus.busy}, 0);
        bus.start = 1'b1;
        tick();
        chk("new_pass_busy", 32'(bus.busy), 1);
        chk("new_pass_addr", {18'd0, bus.enable_read, bus.read_address}, 32'h2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
